// File: rtl/apb_spi_master_v2_if.sv
// APB3 bus bundle for the SPI master.
// The master modport drives requests; the slave modport returns data.
`timescale 1ns/1ps
interface apb_spi_master_v2_if;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PADDR;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (
      output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/apb_spi_master_v2.sv
// APB3 SPI master: register file, TX/RX FIFOs, prescaler, shift engine.
// Back-to-back frames share one CS assertion while TX holds data.
`timescale 1ns/1ps
module apb_spi_master_v2 #(
   parameter int DW         = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int NCS        = 2,
   parameter int PSC_W      = 8
) (
   input  logic               PCLK,
   input  logic               PRESETn,
   apb_spi_master_v2_if.slave apb,
   input  logic               MISO,
   output logic               SCK,
   output logic               MOSI,
   output logic [NCS-1:0]     CS_N,
   output logic               SPI_IRQ
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [5:0] LAST_EDGE = 6'(2*DW-1);

   typedef enum logic [1:0] {
      S_IDLE, S_LEAD, S_XFER, S_TRAIL
   } state_t;

   state_t r_state, w_state_nxt;

   logic             r_en, r_cpol, r_cpha, r_lsb;
   logic [1:0]       r_cssel;
   logic [PSC_W-1:0] r_psc, r_pcnt;
   logic [3:0]       r_ier;
   logic             r_rxovr, r_txovr, r_done, r_irq;
   logic [31:0]      r_prdata;
   logic             r_m_cpha, r_m_lsb;
   logic [NCS-1:0]   r_cs_n;
   logic             r_sck, r_mosi;
   logic [5:0]       r_edge;
   logic [DW-1:0]    r_tsr, r_rsr;

   logic [DW-1:0]    r_tx_mem [FIFO_DEPTH];
   logic [DW-1:0]    r_rx_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_tx_wr, r_tx_rd, r_rx_wr, r_rx_rd;
   logic [CW-1:0]    r_tx_cnt, r_rx_cnt;

   logic [2:0]  w_idx;
   logic        w_wr, w_rd, w_dr_wr, w_sr_wr;
   logic        w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
   logic        w_tx_push, w_tx_drop, w_rx_push, w_rx_drop;
   logic        w_rx_pop, w_go, w_tick, w_last;
   logic        w_busy, w_load, w_end, w_edge, w_done_set;
   logic        w_sample, w_shift, w_new_lsb, w_new_cpha;
   logic [1:0]  w_csel;
   logic [DW-1:0] w_head, w_rsr_nxt, w_rx_word;
   logic [31:0] w_rdata;
   logic        w_unused;

   assign w_idx   = apb.PADDR[4:2];
   assign w_wr    = apb.PSEL & apb.PENABLE & apb.PWRITE;
   assign w_rd    = apb.PSEL & ~apb.PENABLE & ~apb.PWRITE;
   assign w_dr_wr = w_wr & (w_idx == 3'd2);
   assign w_sr_wr = w_wr & (w_idx == 3'd1);
   assign w_unused = ^{apb.PADDR[31:5], apb.PADDR[1:0], apb.PWDATA};

   assign w_tx_empty = (r_tx_cnt == '0);
   assign w_tx_full  = (r_tx_cnt == CW'(FIFO_DEPTH));
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_rx_full  = (r_rx_cnt == CW'(FIFO_DEPTH));

   // A pop in the same cycle frees a slot for a push into a full FIFO
   assign w_tx_push = w_dr_wr & (~w_tx_full | w_load);
   assign w_tx_drop = w_dr_wr & w_tx_full & ~w_load;
   assign w_rx_pop  = w_rd & (w_idx == 3'd2) & ~w_rx_empty;
   assign w_rx_push = w_end & (~w_rx_full | w_rx_pop);
   assign w_rx_drop = w_end & w_rx_full & ~w_rx_pop;

   assign w_go   = r_en & ~w_tx_empty;
   assign w_tick = (r_state != S_IDLE) & (r_pcnt >= r_psc);
   assign w_last = (r_edge == LAST_EDGE);
   assign w_head = r_tx_mem[r_tx_rd];
   assign w_csel = (int'(r_cssel) < NCS) ? r_cssel : 2'd0;

   assign w_new_lsb  = (r_state == S_IDLE) ? r_lsb  : r_m_lsb;
   assign w_new_cpha = (r_state == S_IDLE) ? r_cpha : r_m_cpha;

   // Edges counted from 0: even index is an odd (leading) SCK edge
   assign w_sample = r_m_cpha ? (w_edge & r_edge[0])
                              : (w_edge & ~r_edge[0]);
   assign w_shift  = r_m_cpha ? (w_edge & ~r_edge[0])
                              : (w_edge & r_edge[0] & ~w_last);

   assign w_rsr_nxt = r_m_lsb ? {MISO, r_rsr[DW-1:1]}
                              : {r_rsr[DW-2:0], MISO};
   assign w_rx_word = r_m_cpha ? w_rsr_nxt : r_rsr;

   always_ff @(posedge PCLK) begin
      if (!PRESETn) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_IDLE:  if (w_go) w_state_nxt = S_LEAD;
         S_LEAD:  if (w_tick) w_state_nxt = S_XFER;
         S_XFER:  if (w_tick & w_last & ~w_go)
                     w_state_nxt = S_TRAIL;
         S_TRAIL: if (w_tick) w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_busy     = 1'b0;
      w_load     = 1'b0;
      w_end      = 1'b0;
      w_edge     = 1'b0;
      w_done_set = 1'b0;
      unique case (r_state)
         S_IDLE: w_load = w_go;
         S_LEAD: w_busy = 1'b1;
         S_XFER: begin
            w_busy = 1'b1;
            w_edge = w_tick;
            w_end  = w_tick & w_last;
            w_load = w_tick & w_last & w_go;
         end
         S_TRAIL: begin
            w_busy     = 1'b1;
            w_done_set = w_tick;
         end
      endcase
   end

   always_comb begin
      w_rdata = '0;
      case (w_idx)
         3'd0: w_rdata = {26'd0, r_cssel, r_lsb,
                          r_cpha, r_cpol, r_en};
         3'd1: w_rdata = {24'd0, r_done, r_txovr, r_rxovr,
                          w_rx_full, ~w_rx_empty, w_tx_full,
                          w_tx_empty, w_busy};
         3'd2: w_rdata = w_rx_empty ? 32'd0
                                    : 32'(r_rx_mem[r_rx_rd]);
         3'd3: w_rdata = 32'(r_psc);
         3'd4: w_rdata = {28'd0, r_ier};
         default: w_rdata = '0;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (w_tx_push) r_tx_mem[r_tx_wr] <= apb.PWDATA[DW-1:0];
      if (w_rx_push) r_rx_mem[r_rx_wr] <= w_rx_word;
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         r_en     <= 1'b0;
         r_cpol   <= 1'b0;
         r_cpha   <= 1'b0;
         r_lsb    <= 1'b0;
         r_cssel  <= '0;
         r_psc    <= '0;
         r_pcnt   <= '0;
         r_ier    <= '0;
         r_rxovr  <= 1'b0;
         r_txovr  <= 1'b0;
         r_done   <= 1'b0;
         r_irq    <= 1'b0;
         r_prdata <= '0;
         r_m_cpha <= 1'b0;
         r_m_lsb  <= 1'b0;
         r_cs_n   <= '1;
         r_sck    <= 1'b0;
         r_mosi   <= 1'b0;
         r_edge   <= '0;
         r_tsr    <= '0;
         r_rsr    <= '0;
         r_tx_wr  <= '0;
         r_tx_rd  <= '0;
         r_rx_wr  <= '0;
         r_rx_rd  <= '0;
         r_tx_cnt <= '0;
         r_rx_cnt <= '0;
      end else begin
         if (w_wr & (w_idx == 3'd0)) begin
            r_en    <= apb.PWDATA[0];
            r_cpol  <= apb.PWDATA[1];
            r_cpha  <= apb.PWDATA[2];
            r_lsb   <= apb.PWDATA[3];
            r_cssel <= apb.PWDATA[5:4];
         end
         if (w_wr & (w_idx == 3'd3)) r_psc <= apb.PWDATA[PSC_W-1:0];
         if (w_wr & (w_idx == 3'd4)) r_ier <= apb.PWDATA[3:0];

         r_rxovr <= (r_rxovr & ~(w_sr_wr & apb.PWDATA[5])) | w_rx_drop;
         r_txovr <= (r_txovr & ~(w_sr_wr & apb.PWDATA[6])) | w_tx_drop;
         r_done  <= (r_done  & ~(w_sr_wr & apb.PWDATA[7])) | w_done_set;
         r_irq   <= |(r_ier & {r_done, r_rxovr | r_txovr,
                               ~w_rx_empty, w_tx_empty});
         if (w_rd) r_prdata <= w_rdata;

         if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
         if (w_load)    r_tx_rd <= r_tx_rd + 1'b1;
         r_tx_cnt <= r_tx_cnt + CW'(w_tx_push) - CW'(w_load);
         if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
         if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
         r_rx_cnt <= r_rx_cnt + CW'(w_rx_push) - CW'(w_rx_pop);

         if (w_load & (r_state == S_IDLE)) begin
            r_m_cpha <= r_cpha;
            r_m_lsb  <= r_lsb;
            r_cs_n   <= ~(NCS'(1) << w_csel);
         end else if (w_done_set) begin
            r_cs_n <= '1;
         end

         if (w_load | w_tick) r_pcnt <= '0;
         else if (r_state != S_IDLE) r_pcnt <= r_pcnt + 1'b1;

         if (w_load) r_edge <= '0;
         else if (w_edge) r_edge <= r_edge + 1'b1;

         if (r_state == S_IDLE) r_sck <= r_cpol;
         else if (w_edge) r_sck <= ~r_sck;

         // CPHA=0 presents the first bit at load; CPHA=1 on edge 1
         if (w_load) begin
            if (!w_new_cpha) begin
               r_mosi <= w_new_lsb ? w_head[0] : w_head[DW-1];
               r_tsr  <= w_new_lsb ? (w_head >> 1) : (w_head << 1);
            end else begin
               r_tsr <= w_head;
            end
         end else if (w_shift) begin
            r_mosi <= r_m_lsb ? r_tsr[0] : r_tsr[DW-1];
            r_tsr  <= r_m_lsb ? (r_tsr >> 1) : (r_tsr << 1);
         end

         if (w_sample) r_rsr <= w_rsr_nxt;
      end
   end

   assign apb.PRDATA = r_prdata;
   assign apb.PREADY = 1'b1;
   assign SCK        = r_sck;
   assign MOSI       = r_mosi;
   assign CS_N       = r_cs_n;
   assign SPI_IRQ    = r_irq;
endmodule

// File: tb/tb_apb_spi_master_v2.sv
// Scoreboard bench for apb_spi_master_v2 with MISO looped to MOSI.
// Stimulus queues expected values; a negedge monitor compares them.
`timescale 1ns/1ps
module tb_apb_spi_master_v2;
   localparam int DW    = 8;
   localparam int FD    = 4;
   localparam int NCS   = 2;
   localparam int PSC_W = 8;

   localparam logic [31:0] A_CR  = 32'h00;
   localparam logic [31:0] A_SR  = 32'h04;
   localparam logic [31:0] A_DR  = 32'h08;
   localparam logic [31:0] A_PSC = 32'h0C;
   localparam logic [31:0] A_IER = 32'h10;

   localparam int P_RD   = 0;
   localparam int P_CS   = 1;
   localparam int P_SCK  = 2;
   localparam int P_MOSI = 3;
   localparam int P_IRQ  = 4;
   localparam int P_PRD  = 5;
   localparam int P_MEAS = 6;
   localparam int P_RDY  = 7;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           miso, sck, mosi, irq;
   logic [NCS-1:0] cs_n;

   apb_spi_master_v2_if bus();

   assign miso = mosi;

   apb_spi_master_v2 #(
      .DW(DW), .FIFO_DEPTH(FD), .NCS(NCS), .PSC_W(PSC_W)
   ) dut (
      .PCLK(clk), .PRESETn(rst_n), .apb(bus),
      .MISO(miso), .SCK(sck), .MOSI(mosi),
      .CS_N(cs_n), .SPI_IRQ(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        m_e;
   logic [31:0] m_act;
   int          checks = 0;
   int          errors = 0;
   logic        probe = 1'b0;
   logic [31:0] meas = '0;

   int   cyc = 0;
   int   sck_rise = 0;
   int   sck_hi = 0;
   int   cs_low [NCS] = '{default: 0};
   int   cs_rise_cyc = 0;
   int   irq_rise_cyc = 0;
   logic sck_q = 1'b0;
   logic irq_q = 1'b0;
   logic cs_all_q = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (sck && !sck_q) sck_rise++;
      if (sck) sck_hi++;
      for (int i = 0; i < NCS; i++)
         if (!cs_n[i]) cs_low[i]++;
      if ((&cs_n) && !cs_all_q) cs_rise_cyc = cyc;
      if (irq && !irq_q) irq_rise_cyc = cyc;
      sck_q    = sck;
      irq_q    = irq;
      cs_all_q = &cs_n;
   end

   always @(negedge clk) begin
      if ((bus.PSEL && bus.PENABLE && !bus.PWRITE) || probe) begin
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_sample: nothing queued");
         end else begin
            m_e = exp_q.pop_front();
            case (m_e.sel)
               P_RD:    m_act = bus.PRDATA;
               P_CS:    m_act = 32'(cs_n);
               P_SCK:   m_act = {31'd0, sck};
               P_MOSI:  m_act = {31'd0, mosi};
               P_IRQ:   m_act = {31'd0, irq};
               P_PRD:   m_act = bus.PRDATA;
               P_RDY:   m_act = {31'd0, bus.PREADY};
               default: m_act = meas;
            endcase
            checks++;
            if (m_act !== m_e.exp) begin
               errors++;
               $display("FAIL %s: got 0x%08h expected 0x%08h",
                        m_e.name, m_act, m_e.exp);
            end
         end
      end
   end

   task automatic push_exp(input string nm, input int s,
                           input logic [31:0] v);
      exp_t e;
      e.name = nm;
      e.sel  = s;
      e.exp  = v;
      exp_q.push_back(e);
   endtask

   task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1;
      bus.PADDR = a;   bus.PWDATA = d;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic apb_rd(input logic [31:0] a, input logic [31:0] v,
                         input string nm);
      push_exp(nm, P_RD, v);
      @(posedge clk); #1;
      bus.PSEL = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = a;
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      @(posedge clk); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
   endtask

   task automatic pin(input int s, input logic [31:0] v,
                      input string nm);
      push_exp(nm, s, v);
      probe = 1'b1;
      @(negedge clk); #1;
      probe = 1'b0;
   endtask

   task automatic chk_meas(input int act, input int ev,
                           input string nm);
      meas = 32'(act);
      pin(P_MEAS, 32'(ev), nm);
   endtask

   task automatic wait_done();
      int n0 = 0;
      int n1 = 0;
      while ((&cs_n) && n0 < 2000) begin
         @(posedge clk); #1; n0++;
      end
      while (!(&cs_n) && n1 < 4000) begin
         @(posedge clk); #1; n1++;
      end
      if (n0 >= 2000 || n1 >= 4000) begin
         checks++;
         errors++;
         $display("FAIL wait_done: timeout cs_n=%b expected 11", cs_n);
      end
   endtask

   int b_rise, b_hi, b_c0, b_c1, n;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
      bus.PADDR = '0;  bus.PWDATA = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset while a frame is in flight
      apb_wr(A_PSC, 32'd3);
      apb_wr(A_CR, 32'h01);
      apb_wr(A_DR, 32'h3C);
      n = 0;
      while ((&cs_n) && n < 100) begin
         @(posedge clk); #1; n++;
      end
      repeat (20) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pin(P_CS, 32'h3, "rst_cs_n");
      pin(P_SCK, 32'h0, "rst_sck");
      pin(P_MOSI, 32'h0, "rst_mosi");
      pin(P_IRQ, 32'h0, "rst_irq");
      pin(P_PRD, 32'h0, "rst_prdata");
      rst_n = 1'b1;
      apb_rd(A_SR, 32'h02, "rst_sr");
      apb_rd(A_CR, 32'h00, "rst_cr");
      apb_rd(A_PSC, 32'h00, "rst_psc");
      apb_rd(A_DR, 32'h00, "rst_dr_empty");
      pin(P_RDY, 32'h1, "pready");
      pin(P_CS, 32'h3, "idle_cs_n");

      // Mode 0 loopback
      apb_wr(A_PSC, 32'd1);
      apb_wr(A_CR, 32'h01);
      b_rise = sck_rise; b_hi = sck_hi;
      b_c0 = cs_low[0];  b_c1 = cs_low[1];
      apb_wr(A_DR, 32'hA5);
      wait_done();
      chk_meas(sck_rise - b_rise, 8, "m0_sck_rises");
      chk_meas(sck_hi - b_hi, 16, "m0_sck_high_cycles");
      chk_meas(cs_low[0] - b_c0, 36, "m0_cs0_low_cycles");
      chk_meas(cs_low[1] - b_c1, 0, "m0_cs1_low_cycles");
      apb_rd(A_SR, 32'h8A, "m0_sr");
      apb_rd(A_DR, 32'hA5, "m0_rx");
      apb_rd(A_PSC, 32'h01, "psc_readback");
      apb_rd(32'h14, 32'h0, "unmapped");

      // Burst: mode 3, LSB first, CS1
      apb_wr(A_CR, 32'h1E);
      apb_wr(A_DR, 32'h11);
      apb_wr(A_DR, 32'h22);
      apb_wr(A_DR, 32'h33);
      apb_wr(A_DR, 32'h44);
      apb_wr(A_SR, 32'hE0);
      b_rise = sck_rise;
      b_c0 = cs_low[0];  b_c1 = cs_low[1];
      apb_wr(A_CR, 32'h1F);
      wait_done();
      chk_meas(sck_rise - b_rise, 32, "burst_sck_rises");
      chk_meas(cs_low[1] - b_c1, 132, "burst_cs1_low_cycles");
      chk_meas(cs_low[0] - b_c0, 0, "burst_cs0_low_cycles");
      apb_rd(A_SR, 32'h9A, "burst_sr");
      apb_rd(A_DR, 32'h11, "burst_rx0");
      apb_rd(A_DR, 32'h22, "burst_rx1");
      apb_rd(A_DR, 32'h33, "burst_rx2");
      apb_rd(A_DR, 32'h44, "burst_rx3");
      apb_rd(A_DR, 32'h00, "burst_rx_empty");

      // RX overrun: five frames, no reads in between
      apb_wr(A_CR, 32'h00);
      apb_wr(A_SR, 32'hE0);
      for (int i = 1; i <= 4; i++) apb_wr(A_DR, 32'(i));
      apb_wr(A_CR, 32'h01);
      apb_wr(A_DR, 32'h05);
      wait_done();
      apb_rd(A_SR, 32'hBA, "rxovr_sr");
      for (int i = 1; i <= 4; i++)
         apb_rd(A_DR, 32'(i), "rxovr_rx");
      apb_rd(A_DR, 32'h00, "rxovr_fifth_lost");
      apb_rd(A_SR, 32'hA2, "rxovr_sr_drained");

      // TX overrun with engine disabled
      apb_wr(A_CR, 32'h00);
      apb_wr(A_SR, 32'hE0);
      for (int i = 1; i <= 5; i++) apb_wr(A_DR, 32'h60 + 32'(i));
      apb_rd(A_SR, 32'h44, "txovr_sr");
      apb_wr(A_SR, 32'h40);
      apb_rd(A_SR, 32'h04, "txovr_cleared");
      apb_wr(A_CR, 32'h01);
      wait_done();
      for (int i = 1; i <= 4; i++)
         apb_rd(A_DR, 32'h60 + 32'(i), "txovr_rx");
      apb_rd(A_DR, 32'h00, "txovr_fifth_dropped");

      // DONE interrupt
      apb_wr(A_SR, 32'hE0);
      apb_wr(A_IER, 32'h8);
      apb_rd(A_IER, 32'h8, "ier_readback");
      pin(P_IRQ, 32'h0, "irq_idle");
      apb_wr(A_DR, 32'h5A);
      wait_done();
      repeat (2) @(posedge clk);
      #1;
      chk_meas(irq_rise_cyc - cs_rise_cyc, 1, "irq_delay");
      pin(P_IRQ, 32'h1, "irq_set");
      apb_wr(A_SR, 32'h80);
      pin(P_IRQ, 32'h1, "irq_lag");
      pin(P_IRQ, 32'h0, "irq_cleared");
      apb_rd(A_DR, 32'h5A, "irq_rx");

      repeat (2) @(posedge clk);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover: got %0d queued expected 0",
                  exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
